// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//   Shared definitions for the fifo_arbiter scheduler: default sizing,
//   FSM state encoding and the destination-field helper.
//   No ports.
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int unsigned ARB_NUM_CH    = 4;
    localparam int unsigned ARB_WORD_SIZE = 6;
    localparam int unsigned ARB_PTR_L     = 3;
    localparam int unsigned ARB_CH_L      = 2;

    // Encodings are visible on the state output and must stay fixed.
    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } arb_state_t;

    // Destination output FIFO index carried in the top bits of a word.
    function automatic logic [ARB_CH_L-1:0] dest_of(input logic [ARB_WORD_SIZE-1:0] word);
        return word[ARB_WORD_SIZE-1 -: ARB_CH_L];
    endfunction

endpackage

// File: rtl/fifo_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_arbiter_if
//   FIFO-side bundle between the scheduler and the input/output FIFOs.
//   in_empty        NUM_CH            empty flags of input FIFOs
//   in_data         NUM_CH*WORD_SIZE  show-ahead head words, ch i at [i*WORD_SIZE +: WORD_SIZE]
//   out_almost_full NUM_CH            almost_full flags of output FIFOs
//   fifo_error      2*NUM_CH          error flags, lower half inputs, upper half outputs
//   in_pop          NUM_CH            one-hot pop to input FIFOs
//   out_push        NUM_CH            one-hot push to output FIFOs
//   out_data        WORD_SIZE         word accompanying out_push
//   full_threshold  PTR_L             almost-full threshold to all FIFOs
//   empty_threshold PTR_L             almost-empty threshold to all FIFOs
//   master: scheduler side; slave: FIFO side.
// ---------------------------------------------------------------------------
interface fifo_arbiter_if
    import arb_pkg::*;
#(
    parameter int unsigned NUM_CH    = ARB_NUM_CH,
    parameter int unsigned WORD_SIZE = ARB_WORD_SIZE,
    parameter int unsigned PTR_L     = ARB_PTR_L
);

    logic [NUM_CH-1:0]           in_empty;
    logic [NUM_CH*WORD_SIZE-1:0] in_data;
    logic [NUM_CH-1:0]           out_almost_full;
    logic [2*NUM_CH-1:0]         fifo_error;
    logic [NUM_CH-1:0]           in_pop;
    logic [NUM_CH-1:0]           out_push;
    logic [WORD_SIZE-1:0]        out_data;
    logic [PTR_L-1:0]            full_threshold;
    logic [PTR_L-1:0]            empty_threshold;

    modport master (
        input  in_empty, in_data, out_almost_full, fifo_error,
        output in_pop, out_push, out_data, full_threshold, empty_threshold
    );

    modport slave (
        output in_empty, in_data, out_almost_full, fifo_error,
        input  in_pop, out_push, out_data, full_threshold, empty_threshold
    );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Picks one eligible channel and returns a one-hot grant (combinational).
//   Build option ARB_ROUND_ROBIN_EN:
//     defined   - rotating priority; search starts one past the last popped
//                 channel and wraps; the pointer moves only when advance=1.
//     undefined - fixed priority, lowest eligible index wins; no pointer.
//   clk, reset, advance  (round-robin build only) pointer clock/reset/update
//   eligible  NUM_CH     channels allowed to pop this cycle
//   grant     NUM_CH     one-hot winner, zero when nothing is eligible
// ---------------------------------------------------------------------------
module rr_arbiter
    import arb_pkg::*;
#(
`ifdef ARB_ROUND_ROBIN_EN
    parameter int unsigned CH_L   = ARB_CH_L,
`endif
    parameter int unsigned NUM_CH = ARB_NUM_CH
) (
`ifdef ARB_ROUND_ROBIN_EN
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
`endif
    input  logic [NUM_CH-1:0] eligible,
    output logic [NUM_CH-1:0] grant
);

    logic found;

`ifdef ARB_ROUND_ROBIN_EN
    // ptr holds the first index to search, i.e. last_grant+1.
    logic [CH_L-1:0] ptr;
    logic [CH_L-1:0] idx;
    logic [CH_L-1:0] grant_idx;

    always_comb begin
        grant     = '0;
        found     = 1'b0;
        idx       = '0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = ptr + CH_L'(k);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= grant_idx + CH_L'(1);
        end
    end
`else
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && eligible[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/fifo_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_arbiter
//   Scheduler between NUM_CH input FIFOs and NUM_CH output FIFOs. Pops one
//   word per cycle from a granted input FIFO and pushes it, one cycle later,
//   to the output FIFO named by the word's destination field. Also loads and
//   distributes the almost-full/almost-empty thresholds.
//   Build option ARB_ROUND_ROBIN_EN selects round-robin grant (else fixed).
//   clk, reset        clock, synchronous active-high reset
//   init              request threshold (re)configuration
//   full_th_in        almost-full threshold to load
//   empty_th_in       almost-empty threshold to load
//   bus (master)      FIFO flags/data in; pop/push/data/thresholds out
//   state             FSM state encoding (RESET=0 .. ERROR=4)
//   idle              high in IDLE with every input FIFO empty
// ---------------------------------------------------------------------------
module fifo_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_CH    = ARB_NUM_CH,
    parameter int unsigned WORD_SIZE = ARB_WORD_SIZE,
    parameter int unsigned PTR_L     = ARB_PTR_L,
    parameter int unsigned CH_L      = ARB_CH_L
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [PTR_L-1:0] full_th_in,
    input  logic [PTR_L-1:0] empty_th_in,
    fifo_arbiter_if.master   bus,
    output logic [2:0]       state,
    output logic             idle
);

    arb_state_t           state_q, state_d;
    logic [NUM_CH-1:0]    eligible;
    logic [NUM_CH-1:0]    grant;
    logic [NUM_CH-1:0]    pop;
    logic                 pop_any;
    logic                 any_error;
    logic                 all_empty;
    logic [WORD_SIZE-1:0] head [NUM_CH];
    logic [CH_L-1:0]      dest [NUM_CH];

    logic [NUM_CH-1:0]    push_q;
    logic [WORD_SIZE-1:0] data_q;
    logic [PTR_L-1:0]     full_th_q;
    logic [PTR_L-1:0]     empty_th_q;

    assign any_error = |bus.fifo_error;
    assign all_empty = &bus.in_empty;

    // A channel may pop only if its target output FIFO can still take the word.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            head[i]     = bus.in_data[i*WORD_SIZE +: WORD_SIZE];
            dest[i]     = dest_of(head[i]);
            eligible[i] = !bus.in_empty[i] && !bus.out_almost_full[dest[i]];
        end
    end

    rr_arbiter #(
`ifdef ARB_ROUND_ROBIN_EN
        .CH_L    (CH_L),
`endif
        .NUM_CH  (NUM_CH)
    ) u_arb (
`ifdef ARB_ROUND_ROBIN_EN
        .clk     (clk),
        .reset   (reset),
        .advance (pop_any),
`endif
        .eligible(eligible),
        .grant   (grant)
    );

    // Pops are also withheld on an error cycle so nothing is pushed once ERROR is entered.
    assign pop     = (state_q == ST_ACTIVE && !any_error && !reset) ? grant : '0;
    assign pop_any = |pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (init) begin
                    state_d = ST_INIT;
                end else if (!all_empty) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: if (all_empty && !pop_any) state_d = ST_IDLE;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RESET;
        endcase
        if (state_q != ST_RESET && any_error) begin
            state_d = ST_ERROR;
        end
    end

    // Push/data pipeline stage and threshold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            push_q     <= '0;
            data_q     <= '0;
            full_th_q  <= '0;
            empty_th_q <= '0;
        end else begin
            push_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (pop[i]) begin
                    push_q[dest[i]] <= 1'b1;
                    data_q          <= head[i];
                end
            end
            if (state_q == ST_INIT) begin
                full_th_q  <= full_th_in;
                empty_th_q <= empty_th_in;
            end
        end
    end

    assign bus.in_pop          = pop;
    assign bus.out_push        = push_q;
    assign bus.out_data        = data_q;
    assign bus.full_threshold  = full_th_q;
    assign bus.empty_threshold = empty_th_q;
    assign state               = state_q;
    assign idle                = (state_q == ST_IDLE) && all_empty;

endmodule
